// File: rtl/enc_emu.sv
// enc_emu: quadrature encoder emulator, spreads N steps evenly over a gate window.
// Define ENC_EMU_ILLEGAL_INJ_EN to add the illegal-transition injector.
module enc_emu #(
  parameter int CLK_HZ    = 100_000_000,
  parameter int GATE_HZ   = 200,
  parameter int MINPW_CYC = 50
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic               cmd_valid,
  input  logic signed [15:0] cmd_cnt,
  input  logic               inj_illegal,
  output logic               enc_a,
  output logic               enc_b,
  output logic               win_valid,
  output logic signed [15:0] step_total,
  output logic               clip
);

  localparam int unsigned G       = CLK_HZ / GATE_HZ;
  localparam int unsigned MAXSTEP = G / MINPW_CYC;

  logic [31:0]        gate_q, gate_d;
  logic               gate_pulse;
  logic signed [15:0] pend_q, pend_d;
  logic signed [15:0] ld_cmd;
  logic [16:0]        ld_ext, ld_mag;
  logic               ld_clip;
  logic [16:0]        n_q, n_d;
  logic               fwd_q, fwd_d;
  logic               clip_q, clip_d;
  logic [31:0]        acc_q, acc_d;
  logic [32:0]        sum;
  logic               hit, step;
  logic signed [15:0] delta;
  logic signed [15:0] cnt_q, cnt_d;
  logic signed [15:0] tot_q, tot_d;
  logic               wv_q, wv_d;
  logic [1:0]         ab_q, ab_d;
  logic               inj_rise;

`ifdef ENC_EMU_ILLEGAL_INJ_EN
  logic inj_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) inj_q <= 1'b0;
    else        inj_q <= inj_illegal;
  end

  assign inj_rise = inj_illegal & ~inj_q;
`else
  logic unused_inj;

  assign unused_inj = inj_illegal;
  assign inj_rise   = 1'b0;
`endif

  assign gate_pulse = (gate_q == G - 1);

  // |-32768| must come out as 32768, hence the 17-bit sign extension
  assign ld_cmd  = cmd_valid ? cmd_cnt : pend_q;
  assign ld_ext  = {ld_cmd[15], ld_cmd};
  assign ld_mag  = ld_cmd[15] ? (~ld_ext + 17'd1) : ld_ext;
  assign ld_clip = 32'(ld_mag) > MAXSTEP;

  assign sum  = {16'd0, n_q} + {1'b0, acc_q};
  assign hit  = enable && (sum >= 33'(G));
  assign step = hit && !inj_rise;

  always_comb begin
    delta = 16'sd0;
    if (step) delta = fwd_q ? 16'sd1 : -16'sd1;
  end

  always_comb begin
    gate_d = gate_pulse ? 32'd0 : gate_q + 32'd1;
    pend_d = cmd_valid ? cmd_cnt : pend_q;
    n_d    = n_q;
    fwd_d  = fwd_q;
    clip_d = clip_q;
    if (gate_pulse) begin
      n_d    = ld_clip ? 17'(MAXSTEP) : ld_mag;
      fwd_d  = ~ld_cmd[15];
      clip_d = ld_clip;
    end
  end

  always_comb begin
    acc_d = sum[31:0];
    if (!enable || gate_pulse) acc_d = 32'd0;
    else if (hit)              acc_d = 32'(sum - 33'(G));
  end

  always_comb begin
    cnt_d = cnt_q + delta;
    tot_d = tot_q;
    wv_d  = gate_pulse;
    if (gate_pulse) begin
      tot_d = cnt_q + delta;
      cnt_d = 16'sd0;
    end
  end

  // ab_q is {a,b}; forward walks 00-01-11-10, reverse the other way
  always_comb begin
    ab_d = ab_q;
    if (inj_rise) begin
      ab_d = ~ab_q;
    end else if (step) begin
      case (ab_q)
        2'b00:   ab_d = fwd_q ? 2'b01 : 2'b10;
        2'b01:   ab_d = fwd_q ? 2'b11 : 2'b00;
        2'b11:   ab_d = fwd_q ? 2'b10 : 2'b01;
        default: ab_d = fwd_q ? 2'b00 : 2'b11;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gate_q <= 32'd0;
      pend_q <= 16'sd0;
      n_q    <= 17'd0;
      fwd_q  <= 1'b1;
      clip_q <= 1'b0;
      acc_q  <= 32'd0;
      cnt_q  <= 16'sd0;
      tot_q  <= 16'sd0;
      wv_q   <= 1'b0;
      ab_q   <= 2'b00;
    end else begin
      gate_q <= gate_d;
      pend_q <= pend_d;
      n_q    <= n_d;
      fwd_q  <= fwd_d;
      clip_q <= clip_d;
      acc_q  <= acc_d;
      cnt_q  <= cnt_d;
      tot_q  <= tot_d;
      wv_q   <= wv_d;
      ab_q   <= ab_d;
    end
  end

  assign enc_a      = ab_q[1];
  assign enc_b      = ab_q[0];
  assign win_valid  = wv_q;
  assign step_total = tot_q;
  assign clip       = clip_q;

endmodule

// File: tb/tb_enc_emu.sv
// tb_enc_emu: directed windows for enc_emu at G=100, MAXSTEP=20.
// Window phase ph tracks the DUT gate count; inputs set at ph act in that cycle.
module tb_enc_emu;

  logic               clk = 1'b0;
  logic               rst_n = 1'b1;
  logic               enable = 1'b0;
  logic               cmd_valid = 1'b0;
  logic signed [15:0] cmd_cnt = 16'sd0;
  logic               inj_illegal = 1'b0;
  logic               enc_a, enc_b, win_valid, clip;
  logic signed [15:0] step_total;

  int checks = 0;
  int errors = 0;
  int ph = 0;

  always #5 clk = ~clk;

  enc_emu #(
    .CLK_HZ(1000),
    .GATE_HZ(10),
    .MINPW_CYC(5)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .enable(enable),
    .cmd_valid(cmd_valid),
    .cmd_cnt(cmd_cnt),
    .inj_illegal(inj_illegal),
    .enc_a(enc_a),
    .enc_b(enc_b),
    .win_valid(win_valid),
    .step_total(step_total),
    .clip(clip)
  );

  task automatic tick();
    @(negedge clk);
    ph = (ph + 1) % 100;
  endtask

  function automatic logic [1:0] nxt_ab(input logic [1:0] ab, input bit fwd);
    case (ab)
      2'b00:   return fwd ? 2'b01 : 2'b10;
      2'b01:   return fwd ? 2'b11 : 2'b00;
      2'b11:   return fwd ? 2'b10 : 2'b01;
      default: return fwd ? 2'b00 : 2'b11;
    endcase
  endfunction

  // one full window from ph=0, optionally issuing a command at phase nph
  task automatic run_win(input int n, input bit fwd, input int tot,
                         input bit cl, input bit nv, input int nph,
                         input logic signed [15:0] nc, input string nm);
    logic [1:0] prev;
    logic [1:0] cur;
    int edges = 0;
    int eph;
    for (int i = 0; i < 100; i++) begin
      if (nv && ph == nph) begin
        cmd_valid = 1'b1;
        cmd_cnt   = nc;
      end else begin
        cmd_valid = 1'b0;
        cmd_cnt   = 16'($urandom);
      end
      prev = {enc_a, enc_b};
      tick();
      cur = {enc_a, enc_b};
      if (ph == 50) begin
        checks++;
        if (clip !== cl || win_valid !== 1'b0) begin
          errors++;
          $display("FAIL %s mid: clip=%b win_valid=%b, need clip=%b win_valid=0",
                   nm, clip, win_valid, cl);
        end
      end
      if (cur !== prev) begin
        edges++;
        eph = (n > 0) ? ((edges * 100 + n - 1) / n) % 100 : -1;
        checks++;
        if (cur !== nxt_ab(prev, fwd) || ph != eph) begin
          errors++;
          $display("FAIL %s edge%0d: ab %b->%b at ph %0d, need ->%b at ph %0d",
                   nm, edges, prev, cur, ph, nxt_ab(prev, fwd), eph);
        end
      end
    end
    cmd_valid = 1'b0;
    checks++;
    if (win_valid !== 1'b1 || step_total !== 16'(tot) || edges != n) begin
      errors++;
      $display("FAIL %s close: win_valid=%b step_total=%0d edges=%0d, need 1 %0d %0d",
               nm, win_valid, step_total, edges, tot, n);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({enc_a, enc_b, win_valid, clip} !== 4'b0000 || step_total !== 16'sd0) begin
      errors++;
      $display("FAIL reset: ab=%b%b wv=%b clip=%b tot=%0d, need all 0",
               enc_a, enc_b, win_valid, clip, step_total);
    end
    repeat (3) @(negedge clk);
    rst_n  = 1'b1;
    ph     = 0;
    enable = 1'b1;
  endtask

  task automatic test_forward();
    run_win(0, 1'b1, 0, 1'b0, 1'b1, 10, 16'sd4, "idle");
    run_win(4, 1'b1, 4, 1'b0, 1'b1, 10, -16'sd3, "fwd4");
    checks++;
    if ({enc_a, enc_b} !== 2'b00) begin
      errors++;
      $display("FAIL fwd4_end: ab=%b%b, need 00", enc_a, enc_b);
    end
  endtask

  task automatic test_reverse();
    run_win(3, 1'b0, -3, 1'b0, 1'b1, 10, 16'sd50, "rev3");
    checks++;
    if ({enc_a, enc_b} !== 2'b01) begin
      errors++;
      $display("FAIL rev3_end: ab=%b%b, need 01", enc_a, enc_b);
    end
  endtask

  task automatic test_clip();
    run_win(20, 1'b1, 20, 1'b1, 1'b1, 10, -16'sd32768, "clip_pos");
    run_win(20, 1'b0, -20, 1'b1, 1'b1, 10, 16'sd2, "clip_neg");
  endtask

  task automatic test_cmd_on_gate();
    run_win(2, 1'b1, 2, 1'b0, 1'b1, 99, 16'sd7, "gate_cmd");
    run_win(7, 1'b1, 7, 1'b0, 1'b1, 10, 16'sd10, "cmd7");
  endtask

  task automatic test_enable_gap();
    logic [1:0] prev;
    int edges = 0;
    for (int i = 0; i < 100; i++) begin
      if (ph == 50) enable = 1'b0;
      prev = {enc_a, enc_b};
      tick();
      if ({enc_a, enc_b} !== prev) edges++;
    end
    checks++;
    if (edges != 5 || {enc_a, enc_b} !== 2'b10) begin
      errors++;
      $display("FAIL en_gap_ab: edges=%0d ab=%b%b, need 5 10", edges, enc_a, enc_b);
    end
    checks++;
    if (win_valid !== 1'b1 || step_total !== 16'sd5) begin
      errors++;
      $display("FAIL en_gap_tot: wv=%b tot=%0d, need 1 5", win_valid, step_total);
    end
    enable = 1'b1;
  endtask

  task automatic test_reset_mid();
    while (ph != 30) tick();
    checks++;
    if ({enc_a, enc_b} !== 2'b11) begin
      errors++;
      $display("FAIL pre_rst: ab=%b%b, need 11", enc_a, enc_b);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({enc_a, enc_b, win_valid, clip} !== 4'b0000 || step_total !== 16'sd0) begin
      errors++;
      $display("FAIL rst_mid: ab=%b%b wv=%b clip=%b tot=%0d, need all 0",
               enc_a, enc_b, win_valid, clip, step_total);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ph    = 0;
    run_win(0, 1'b1, 0, 1'b0, 1'b1, 10, 16'sd1, "post_rst");
  endtask

`ifdef ENC_EMU_ILLEGAL_INJ_EN
  task automatic test_inject();
    logic [1:0] prev;
    logic [1:0] cur;
    int ill = 0;
    run_win(1, 1'b1, 1, 1'b0, 1'b1, 10, 16'sd0, "one_step");
    while (ph != 5) tick();
    inj_illegal = 1'b1;
    prev = {enc_a, enc_b};
    tick();
    checks++;
    if ({enc_a, enc_b} !== 2'b10) begin
      errors++;
      $display("FAIL inject_ab: ab=%b%b, need 10", enc_a, enc_b);
    end
    if (({enc_a, enc_b} ^ prev) == 2'b11) ill++;
    while (ph != 0) begin
      prev = {enc_a, enc_b};
      tick();
      cur = {enc_a, enc_b};
      if ((cur ^ prev) == 2'b11) ill++;
    end
    inj_illegal = 1'b0;
    checks++;
    if (ill != 1 || win_valid !== 1'b1 || step_total !== 16'sd0) begin
      errors++;
      $display("FAIL inject_cnt: illegal=%0d wv=%b tot=%0d, need 1 1 0",
               ill, win_valid, step_total);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_forward();
    test_reverse();
    test_clip();
    test_cmd_on_gate();
    test_enable_gap();
    test_reset_mid();
`ifdef ENC_EMU_ILLEGAL_INJ_EN
    test_inject();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
